alu_muldiv_ctrl: RTL and testbench
==================================

// Module: alu_muldiv_ctrl
// PURPOSE
//  Next-generation EX-stage ALU control. Decodes alu_op/func3/func7 to the 4-bit ALU alufn for RV32I R/I-type ops.
//  Adds RV32M support: a multi-cycle iterative multiply/divide sequencer that stalls the pipeline until the result is ready.
//  Sits between ID/EX pipeline register and EX-stage result mux; base ALU path stays single-cycle.
// PARAMETERS
//  XLEN      32  operand/result width (>=8, power of 2)
//  FAST_MUL  0   1: MUL* uses one combinational XLENxXLEN multiply, latency 1; 0: radix-2 shift-add, XLEN iterations
// PORTS
//  clk           in   1     clock, all state on rising edge
//  rst           in   1     synchronous, active-high reset
//  alu_op        in   2     00 add, 01 sub, 10 R-type, 11 I-type
//  func7         in   7     instr[31:25]
//  func3         in   3     instr[14:12]
//  ex_valid      in   1     valid instruction present in EX
//  flush         in   1     EX squash (branch/jump taken); synchronous abort
//  rs1_val       in   XLEN  operand A
//  rs2_val       in   XLEN  operand B
//  alufn         out  4     base ALU function (combinational)
//  is_m          out  1     alu_op==10 && func7==0000001 (combinational)
//  stall         out  1     hold IF/ID/EX; = ex_valid & is_m & ~done & ~rst & ~flush
//  md_result     out  XLEN  M-extension result, registered
//  md_valid      out  1     high for exactly one cycle, in DONE
// BEHAVIOUR
//  Base decode identical to existing alu_op encoding: 00->ADD, 01->SUB, 10/11 by func3 (func7[5] selects SUB/SRA);
//   unknown combos and all M ops -> alufn=0. Pure combinational, zero latency.
//  FSM states: IDLE, MUL, DIV, DONE.
//   IDLE: ex_valid&is_m&~flush -> latch operands, signs, func3; func3[2]=0 -> MUL (FAST_MUL=1: DONE); func3[2]=1 -> DIV.
//   DIV special cases detected in IDLE, go straight to DONE:
//    divisor==0: DIV/DIVU q=all ones; REM/REMU r=dividend.
//    DIV/REM with dividend=0x8..0, divisor=-1: q=dividend, r=0.
//   MUL/DIV: iterate with cnt from 0 to XLEN-1 (width $clog2(XLEN)+1), one bit per cycle; at cnt==XLEN-1 -> DONE.
//   DONE: md_valid=1, md_result valid, stall=0 so pipeline advances; unconditional -> IDLE next cycle.
//  Arithmetic: operate on magnitudes, 2*XLEN product register; sign fix-up at end.
//   MUL low XLEN; MULH s*s, MULHSU s*u, MULHU u*u upper XLEN.
//   DIV/DIVU quotient, REM/REMU remainder; remainder takes dividend sign.
//  Latency (accept cycle T): iterative ops md_valid at T+XLEN+1; FAST_MUL mul and div special cases at T+1.
//  Back-to-back M ops: second accepted in the IDLE cycle after DONE; no result overwrites before md_valid.
//  flush in any state: next cycle IDLE, md_valid=0, md_result held; flush in DONE suppresses nothing already seen.
//  flush and accept same cycle: flush wins, no accept.
//  rst (any state, incl. mid-iteration): state=IDLE, cnt=0, md_result=0, md_valid=0; stall forced 0 while rst high.
//  Non-M instruction in EX: FSM stays IDLE, stall=0.
// STRUCTURE
//  Shared defines file: ALU_* alufn codes, F3_*/F7_* codes incl. F7_MULDIV=7'b0000001, F3_MUL..F3_REMU, FSM state encodings.
//  One sub-module: muldiv_iter (operand registers, shift-add/restoring-divide datapath, cnt); top holds decode, FSM, stall.
// TESTING
//  MUL: rs1=7, rs2=-3 (0xFFFFFFFD), FAST_MUL=0 -> md_result=0xFFFFFFEB, md_valid at T+33, stall high T..T+32.
//  MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU -1*2 -> 0xFFFFFFFF.
//  DIV 100/0 -> 0xFFFFFFFF, REMU 100%0 -> 100, both at T+1; DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
//  DIV -7/2 -> 0xFFFFFFFD, REM -7%2 -> 0xFFFFFFFF; REMU 100%7 -> 2; back-to-back DIV then MUL both correct.
//  flush at cycle T+10 of DIV -> IDLE at T+11, md_valid never pulses; rst at T+5 -> all outputs 0 next cycle.
//  Base ops: alu_op=10 func3=000 func7=0100000 -> ALU_SUB, stall=0; alu_op=11 func3=101 func7=0100000 -> ALU_SRA.

Source files
------------

// File: rtl/alu_muldiv_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// alu_muldiv_ctrl_pkg
// Shared definitions for the EX-stage ALU control and the RV32M sequencer:
//   - alu_op encodings coming from the ID stage
//   - 4-bit base ALU function codes (alufn = {func7[5], func3} style)
//   - func3 / func7 instruction field codes, including the M-extension ops
//   - FSM state encoding of the multiply/divide sequencer
// ----------------------------------------------------------------------------
package alu_muldiv_ctrl_pkg;

    // alu_op from the decoder
    localparam logic [1:0] AOP_ADD   = 2'b00;
    localparam logic [1:0] AOP_SUB   = 2'b01;
    localparam logic [1:0] AOP_RTYPE = 2'b10;
    localparam logic [1:0] AOP_ITYPE = 2'b11;

    // Base ALU function codes. ALU_ADD doubles as the "no operation" value
    // for unknown encodings and for M-extension instructions.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    // Base integer func3
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // M-extension func3
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // func7
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_t;

    // func3 -> ALU function for the "plain" variant of each base op
    function automatic logic [3:0] base_alufn(input logic [2:0] f3);
        logic [3:0] fn;
        case (f3)
            F3_ADD_SUB: fn = ALU_ADD;
            F3_SLL:     fn = ALU_SLL;
            F3_SLT:     fn = ALU_SLT;
            F3_SLTU:    fn = ALU_SLTU;
            F3_XOR:     fn = ALU_XOR;
            F3_SR:      fn = ALU_SRL;
            F3_OR:      fn = ALU_OR;
            default:    fn = ALU_AND;
        endcase
        return fn;
    endfunction

endpackage

// File: rtl/alu_muldiv_ctrl_muldiv_iter.sv
// ----------------------------------------------------------------------------
// alu_muldiv_ctrl_muldiv_iter
// Iterative multiply/divide datapath. Works on operand magnitudes in a
// 2*XLEN accumulator: radix-2 shift-add for MUL*, restoring division for
// DIV*/REM*, one bit per step. Sign fix-up is applied to the final value.
// Ports:
//   clk, srst      clock, synchronous active-high reset
//   start          latch operands/func3/signs and initialise the accumulator
//   step           perform one iteration (advances cnt)
//   func3          M-extension func3 of the op being started
//   a, b           raw operands (rs1, rs2)
//   last           current step is the final one (cnt == XLEN-1)
//   start_done     op completes without iterating (div special case / fast mul)
//   start_result   result for a start_done op, from the raw operands
//   step_result    sign-corrected result after the current step
// ----------------------------------------------------------------------------
module alu_muldiv_ctrl_muldiv_iter
    import alu_muldiv_ctrl_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int FAST_MUL = 0
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            start,
    input  logic            step,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            last,
    output logic            start_done,
    output logic [XLEN-1:0] start_result,
    output logic [XLEN-1:0] step_result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    logic [2:0]        func3_reg;
    logic              sign_a_reg;
    logic              sign_b_reg;
    logic [XLEN-1:0]   opnd_reg;      // multiplicand (MUL*) or divisor (DIV*)
    logic [2*XLEN-1:0] acc_reg;       // {hi, lo}: product, or {remainder, quotient}
    logic [2*XLEN-1:0] acc_next;
    logic [CW-1:0]     cnt_reg;

    // Maps the magnitude-domain accumulator to the architectural result.
    // Sign flags are only ever set for the signed variants, so unsigned ops
    // pass straight through.
    function automatic logic [XLEN-1:0] fixup(input logic [2:0] f3,
                                              input logic sa,
                                              input logic sb,
                                              input logic [2*XLEN-1:0] v);
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   q;
        logic [XLEN-1:0]   r;
        logic [XLEN-1:0]   res;
        p = (sa ^ sb) ? -v : v;
        q = (sa ^ sb) ? -v[XLEN-1:0] : v[XLEN-1:0];
        r = sa ? -v[2*XLEN-1:XLEN] : v[2*XLEN-1:XLEN];   // remainder follows dividend
        case (f3)
            F3_MUL:                       res = p[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: res = p[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              res = q;
            default:                      res = r;
        endcase
        return res;
    endfunction

    // Operand signedness and magnitudes
    logic            signed_a;
    logic            signed_b;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;

    assign signed_a = (func3 == F3_MULH) || (func3 == F3_MULHSU) ||
                      (func3 == F3_DIV)  || (func3 == F3_REM);
    assign signed_b = (func3 == F3_MULH) || (func3 == F3_DIV) || (func3 == F3_REM);
    assign sign_a   = signed_a & a[XLEN-1];
    assign sign_b   = signed_b & b[XLEN-1];
    assign mag_a    = sign_a ? -a : a;
    assign mag_b    = sign_b ? -b : b;

    logic [2*XLEN-1:0] fast_prod;
    generate
        if (FAST_MUL != 0) begin : g_fast_mul
            assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
        end else begin : g_iter_mul
            assign fast_prod = '0;
        end
    endgenerate

    // Ops that finish in the accept cycle
    logic div_zero;
    logic div_ovf;
    assign div_zero = (b == '0);
    assign div_ovf  = ((func3 == F3_DIV) || (func3 == F3_REM)) &&
                      (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);

    always_comb begin
        start_done   = 1'b0;
        start_result = '0;
        if (func3[2]) begin
            if (div_zero) begin
                start_done   = 1'b1;
                start_result = func3[1] ? a : '1;
            end else if (div_ovf) begin
                start_done   = 1'b1;
                start_result = func3[1] ? '0 : a;
            end
        end else if (FAST_MUL != 0) begin
            start_done   = 1'b1;
            start_result = fixup(func3, sign_a, sign_b, fast_prod);
        end
    end

    // One iteration of the shared datapath
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN+1:0] div_diff;

    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} +
                    (acc_reg[0] ? {1'b0, opnd_reg} : {(XLEN+1){1'b0}});
        div_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opnd_reg};
        if (!func3_reg[2]) begin
            acc_next = {mul_sum, acc_reg[XLEN-1:1]};
        end else if (!div_diff[XLEN+1]) begin
            // No borrow: the partial remainder is below the divisor, so it fits XLEN bits
            acc_next = {div_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
        end else begin
            acc_next = {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
        end
    end

    logic unused_bits;
    assign unused_bits = ^{div_diff[XLEN], div_shift[XLEN]};

    assign last        = (cnt_reg == CNT_LAST);
    assign step_result = fixup(func3_reg, sign_a_reg, sign_b_reg, acc_next);

    always_ff @(posedge clk) begin
        if (srst) begin
            func3_reg  <= '0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            opnd_reg   <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
        end else if (start) begin
            func3_reg  <= func3;
            sign_a_reg <= sign_a;
            sign_b_reg <= sign_b;
            cnt_reg    <= '0;
            if (func3[2]) begin
                opnd_reg <= mag_b;
                acc_reg  <= {{XLEN{1'b0}}, mag_a};
            end else begin
                opnd_reg <= mag_a;
                acc_reg  <= {{XLEN{1'b0}}, mag_b};
            end
        end else if (step) begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/alu_muldiv_ctrl.sv
// ----------------------------------------------------------------------------
// alu_muldiv_ctrl
// EX-stage ALU control: combinational base-ALU decode plus an RV32M
// multiply/divide sequencer that stalls the pipeline until its result is ready.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   alu_op            00 add, 01 sub, 10 R-type, 11 I-type
//   func7, func3      instruction fields
//   ex_valid          valid instruction in EX
//   flush             EX squash, aborts any M op in flight
//   rs1_val, rs2_val  operands
//   alufn             base ALU function (combinational)
//   is_m              M-extension instruction in EX (combinational)
//   stall             hold IF/ID/EX while an M op is in progress
//   md_result         registered M-extension result
//   md_valid          one-cycle pulse when md_result is new
// ----------------------------------------------------------------------------
module alu_muldiv_ctrl
    import alu_muldiv_ctrl_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int FAST_MUL = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      alu_op,
    input  logic [6:0]      func7,
    input  logic [2:0]      func3,
    input  logic            ex_valid,
    input  logic            flush,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic [3:0]      alufn,
    output logic            is_m,
    output logic            stall,
    output logic [XLEN-1:0] md_result,
    output logic            md_valid
);

    // Base decode
    always_comb begin
        alufn = ALU_ADD;
        case (alu_op)
            AOP_ADD: alufn = ALU_ADD;
            AOP_SUB: alufn = ALU_SUB;
            AOP_RTYPE: begin
                if (func7 == F7_BASE) begin
                    alufn = base_alufn(func3);
                end else if (func7 == F7_ALT) begin
                    if (func3 == F3_ADD_SUB) alufn = ALU_SUB;
                    else if (func3 == F3_SR) alufn = ALU_SRA;
                end
            end
            default: begin
                // I-type: func7 is immediate except for the shift-amount forms
                case (func3)
                    F3_SLL: if (func7 == F7_BASE) alufn = ALU_SLL;
                    F3_SR: begin
                        if (func7 == F7_BASE)     alufn = ALU_SRL;
                        else if (func7 == F7_ALT) alufn = ALU_SRA;
                    end
                    default: alufn = base_alufn(func3);
                endcase
            end
        endcase
    end

    assign is_m = (alu_op == AOP_RTYPE) && (func7 == F7_MULDIV);

    // Sequencer
    md_state_t       state_reg;
    md_state_t       state_next;
    logic [XLEN-1:0] md_result_reg;
    logic [XLEN-1:0] md_result_next;

    logic            accept;
    logic            step;
    logic            last;
    logic            start_done;
    logic [XLEN-1:0] start_result;
    logic [XLEN-1:0] step_result;

    assign accept = (state_reg == ST_IDLE) && ex_valid && is_m && !flush;
    assign step   = ((state_reg == ST_MUL) || (state_reg == ST_DIV)) && !flush;

    alu_muldiv_ctrl_muldiv_iter #(
        .XLEN     (XLEN),
        .FAST_MUL (FAST_MUL)
    ) u_muldiv_iter (
        .clk          (clk),
        .srst         (rst),
        .start        (accept),
        .step         (step),
        .func3        (func3),
        .a            (rs1_val),
        .b            (rs2_val),
        .last         (last),
        .start_done   (start_done),
        .start_result (start_result),
        .step_result  (step_result)
    );

    always_comb begin
        state_next     = state_reg;
        md_result_next = md_result_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (start_done) begin
                        state_next     = ST_DONE;
                        md_result_next = start_result;
                    end else begin
                        state_next = func3[2] ? ST_DIV : ST_MUL;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (last) begin
                    state_next     = ST_DONE;
                    md_result_next = step_result;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // Squash: abandon the op and keep the previously published result
        if (flush) begin
            state_next     = ST_IDLE;
            md_result_next = md_result_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            md_result_reg <= '0;
        end else begin
            state_reg     <= state_next;
            md_result_reg <= md_result_next;
        end
    end

    assign md_result = md_result_reg;
    assign md_valid  = (state_reg == ST_DONE);
    assign stall     = ex_valid && is_m && (state_reg != ST_DONE) && !rst && !flush;

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// ----------------------------------------------------------------------------
// tb_alu_muldiv_ctrl
// Self-checking bench for alu_muldiv_ctrl (XLEN=32, FAST_MUL=0). Inputs are
// driven 1ns after the rising edge, outputs sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_alu_muldiv_ctrl;
    import alu_muldiv_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  alu_op;
    logic [6:0]  func7;
    logic [2:0]  func3;
    logic        ex_valid;
    logic        flush;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [3:0]  alufn;
    logic        is_m;
    logic        stall;
    logic [31:0] md_result;
    logic        md_valid;

    int          vectors    = 0;
    int          miscompares = 0;
    logic [31:0] last_result = 32'h0;

    always #5 clk = ~clk;

    alu_muldiv_ctrl #(.XLEN(32), .FAST_MUL(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_op    (alu_op),
        .func7     (func7),
        .func3     (func3),
        .ex_valid  (ex_valid),
        .flush     (flush),
        .rs1_val   (rs1_val),
        .rs2_val   (rs2_val),
        .alufn     (alufn),
        .is_m      (is_m),
        .stall     (stall),
        .md_result (md_result),
        .md_valid  (md_valid)
    );

    // ---------------- reference models ----------------
    function automatic logic [3:0] ref_alufn(input logic [1:0] aop, input logic [2:0] f3,
                                             input logic [6:0] f7);
        logic [3:0] plain [8];
        plain[0] = ALU_ADD; plain[1] = ALU_SLL; plain[2] = ALU_SLT; plain[3] = ALU_SLTU;
        plain[4] = ALU_XOR; plain[5] = ALU_SRL; plain[6] = ALU_OR;  plain[7] = ALU_AND;
        if (aop == 2'b00) return ALU_ADD;
        if (aop == 2'b01) return ALU_SUB;
        if (aop == 2'b10) begin
            if (f7 == 7'h00) return plain[f3];
            if (f7 == 7'h20 && f3 == 3'd0) return ALU_SUB;
            if (f7 == 7'h20 && f3 == 3'd5) return ALU_SRA;
            return 4'd0;
        end
        if (f3 == 3'd1) return (f7 == 7'h00) ? ALU_SLL : 4'd0;
        if (f3 == 3'd5) return (f7 == 7'h00) ? ALU_SRL : ((f7 == 7'h20) ? ALU_SRA : 4'd0);
        return plain[f3];
    endfunction

    function automatic logic is_special(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
        return f3[2] && ((b == 32'h0) ||
               (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        longint      t;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        ub = longint'({32'h0, b});
        case (f3)
            3'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
            3'd1: begin t = sa * sb; p = t; return p[63:32]; end
            3'd2: begin t = sa * ub; p = t; return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                t = sa / sb; p = t; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                t = sa % sb; p = t; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] corner [4];
        corner[0] = 32'h0; corner[1] = 32'hFFFF_FFFF; corner[2] = 32'h8000_0000; corner[3] = 32'h1;
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
        return $urandom;
    endfunction

    // ---------------- M-op transaction ----------------
    // Called 1ns after a rising edge; returns 1ns after the edge that ends DONE,
    // with ex_valid dropped, so a following call issues back-to-back.
    task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input string name);
        logic [31:0] exp_v;
        int          exp_lat;
        int          lat;
        bit          seen;
        exp_v   = ref_md(f3, a, b);
        exp_lat = is_special(f3, a, b) ? 1 : 33;
        ex_valid = 1'b1; alu_op = 2'b10; func7 = 7'b0000001; func3 = f3;
        rs1_val  = a;    rs2_val = b;    flush = 1'b0;
        @(negedge clk);
        vectors++;
        if (stall !== 1'b1) begin
            miscompares++;
            $display("FAIL %s accept_stall: got %b want 1", name, stall);
        end
        lat  = 0;
        seen = 0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (md_valid === 1'b1) begin
                seen = 1;
            end else begin
                vectors++;
                if (stall !== 1'b1 || md_result !== last_result) begin
                    miscompares++;
                    $display("FAIL %s busy_cycle%0d: stall=%b md_result=%h want stall=1 md_result=%h",
                             name, lat, stall, md_result, last_result);
                end
            end
        end
        vectors++;
        if (!seen || lat != exp_lat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d (seen=%0d) want %0d", name, lat, seen, exp_lat);
        end
        vectors++;
        if (md_result !== exp_v) begin
            miscompares++;
            $display("FAIL %s result: got %h want %h (a=%h b=%h)", name, md_result, exp_v, a, b);
        end
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done_stall: got %b want 0", name, stall);
        end
        $display("txn %-8s f3=%0d a=%h b=%h -> %h lat=%0d", name, f3, a, b, md_result, lat);
        last_result = exp_v;
        @(posedge clk); #1;
        ex_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        ex_valid = 1'b1; alu_op = 2'b10; func7 = 7'b0000001; func3 = 3'd0;
        rs1_val = 32'd5; rs2_val = 32'd6;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (stall !== 1'b0 || md_valid !== 1'b0 || md_result !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_hold: stall=%b md_valid=%b md_result=%h want 0/0/0",
                     stall, md_valid, md_result);
        end
        @(posedge clk); #1;
        rst = 1'b0; ex_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (stall !== 1'b0 || md_valid !== 1'b0 || md_result !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_release: stall=%b md_valid=%b md_result=%h want 0/0/0",
                     stall, md_valid, md_result);
        end
        $display("txn reset     stall=%b md_valid=%b md_result=%h", stall, md_valid, md_result);
        @(posedge clk); #1;
    endtask

    task automatic test_decode();
        logic [1:0] aops [5];
        logic [2:0] f3s  [5];
        logic [6:0] f7s  [5];
        logic [1:0] aop;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       exp_m;
        aops[0] = 2'b10; f3s[0] = 3'b000; f7s[0] = 7'b0100000;   // SUB
        aops[1] = 2'b11; f3s[1] = 3'b101; f7s[1] = 7'b0100000;   // SRAI
        aops[2] = 2'b00; f3s[2] = 3'b111; f7s[2] = 7'b0000000;   // forced ADD
        aops[3] = 2'b01; f3s[3] = 3'b010; f7s[3] = 7'b0000000;   // forced SUB
        aops[4] = 2'b10; f3s[4] = 3'b100; f7s[4] = 7'b0000001;   // DIV -> alufn 0
        for (int i = 0; i < 45; i++) begin
            if (i < 5) begin
                aop = aops[i]; f3 = f3s[i]; f7 = f7s[i];
            end else begin
                aop = 2'($urandom);
                f3  = 3'($urandom);
                case ($urandom_range(0, 3))
                    0: f7 = 7'h00;
                    1: f7 = 7'h20;
                    2: f7 = 7'h01;
                    default: f7 = 7'($urandom);
                endcase
            end
            exp_m    = (aop == 2'b10) && (f7 == 7'h01);
            alu_op   = aop; func3 = f3; func7 = f7;
            ex_valid = !exp_m;    // keep M ops out of the sequencer here
            rs1_val  = $urandom;  rs2_val = $urandom;
            @(negedge clk);
            vectors++;
            if (alufn !== ref_alufn(aop, f3, f7) || is_m !== exp_m || stall !== 1'b0 ||
                md_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL decode%0d: op=%b f3=%b f7=%b alufn=%h is_m=%b stall=%b md_valid=%b want alufn=%h is_m=%b stall=0 md_valid=0",
                         i, aop, f3, f7, alufn, is_m, stall, md_valid,
                         ref_alufn(aop, f3, f7), exp_m);
            end
            $display("txn decode op=%b f3=%b f7=%b -> alufn=%h is_m=%b", aop, f3, f7, alufn, is_m);
            @(posedge clk); #1;
        end
        ex_valid = 1'b0;
    endtask

    task automatic test_mul_directed();
        run_md(F3_MUL,    32'd7,        32'hFFFF_FFFD, "mul");
        run_md(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
        run_md(F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh");
        run_md(F3_MULHSU, 32'hFFFF_FFFF, 32'd2,        "mulhsu");
    endtask

    task automatic test_div_directed();
        run_md(F3_DIV,  32'd100,       32'd0,         "div0");
        run_md(F3_REMU, 32'd100,       32'd0,         "remu0");
        run_md(F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "divovf");
        run_md(F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, "removf");
        run_md(F3_DIV,  32'hFFFF_FFF9, 32'd2,         "div");
        run_md(F3_REM,  32'hFFFF_FFF9, 32'd2,         "rem");
        run_md(F3_REMU, 32'd100,       32'd7,         "remu");
    endtask

    task automatic test_back_to_back();
        run_md(F3_DIV, $urandom, 32'($urandom_range(1, 1000)), "b2b_div");
        run_md(F3_MUL, $urandom, $urandom,                      "b2b_mul");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_md(3'($urandom), pick_operand(), pick_operand(), "random");
        end
    endtask

    task automatic test_flush();
        // Flush at T+10 of a DIV; the next op issued at T+11 must see an IDLE
        // sequencer (latency counted from its own accept) and no stray pulse.
        ex_valid = 1'b1; alu_op = 2'b10; func7 = 7'b0000001; func3 = F3_DIV;
        rs1_val = 32'd1000; rs2_val = 32'd3; flush = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        vectors++;
        if (stall !== 1'b0 || md_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_cycle: stall=%b md_valid=%b want 0/0", stall, md_valid);
        end
        $display("txn flush mid-div stall=%b", stall);
        @(posedge clk); #1;
        flush = 1'b0;
        run_md(F3_REMU, 32'd12345, 32'd100, "post_flush");

        // Flush coinciding with an accept: the op must not start
        ex_valid = 1'b1; alu_op = 2'b10; func7 = 7'b0000001; func3 = F3_MUL;
        rs1_val = 32'd9; rs2_val = 32'd9; flush = 1'b1;
        @(negedge clk);
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_accept_stall: got %b want 0", stall);
        end
        $display("txn flush+accept stall=%b", stall);
        @(posedge clk); #1;
        flush = 1'b0;
        run_md(F3_DIVU, 32'd77, 32'd0, "post_flush_acc");
    endtask

    task automatic test_rst_mid();
        ex_valid = 1'b1; alu_op = 2'b10; func7 = 7'b0000001; func3 = F3_MULHU;
        rs1_val = $urandom; rs2_val = $urandom; flush = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_stall: got %b want 0", stall);
        end
        @(posedge clk); #1;
        rst = 1'b0; ex_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (stall !== 1'b0 || md_valid !== 1'b0 || md_result !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: stall=%b md_valid=%b md_result=%h want 0/0/0",
                     stall, md_valid, md_result);
        end
        $display("txn rst mid-mul stall=%b md_valid=%b md_result=%h", stall, md_valid, md_result);
        last_result = 32'h0;
        @(posedge clk); #1;
        run_md(F3_MUL, 32'd3, 32'd5, "post_rst");
    endtask

    initial begin
        test_reset();
        test_decode();
        test_mul_directed();
        test_div_directed();
        test_back_to_back();
        test_random();
        test_flush();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
